// File: rtl/led_value_uart_tx.sv
// led_value_uart_tx: sends the upstream LED count as an 8N1 UART byte
// whenever it changes. While a frame is on the line, one newer value can wait
// in a one-entry pending slot. If a later change overwrites that slot, the
// block flags it with a single-cycle overrun pulse.
module led_value_uart_tx #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  value_q;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic        pend_valid_q, pend_valid_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  logic        change;
  logic        bit_end;
  logic        slot_free;

  // Compare against the previous-cycle value; value_q updates on the same edge.
  assign change    = (value != value_q);
  assign bit_end   = (timer_q == BIT_LAST);
  // At the last cycle of STOP, the pending slot is drained into the next frame.
  assign slot_free = (state_q == STOP) && bit_end;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    timer_d      = timer_q;
    idx_d        = idx_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    overrun_d    = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        if (change) begin
          state_d = START;
          shift_d = value;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[idx_q + 3'd1];
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          idx_d   = '0;
          if (pend_valid_q) begin
            // The pending byte goes out next. A change on this same edge
            // refills the slot, so pend_valid stays set.
            state_d      = START;
            shift_d      = pend_data_q;
            tx_d         = 1'b0;
            pend_valid_d = change;
            if (change) pend_data_d = value;
          end else if (change) begin
            state_d = START;
            shift_d = value;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Mid-frame changes land in the slot, and the newest value wins.
    if ((state_q != IDLE) && change && !slot_free) begin
      pend_data_d  = value;
      pend_valid_d = 1'b1;
      overrun_d    = pend_valid_q;
    end
  end

  // State and output registers; reset aborts any frame and drops the pending byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      value_q      <= '0;
      shift_q      <= '0;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      timer_q      <= '0;
      idx_q        <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      value_q      <= value;
      shift_q      <= shift_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_led_value_uart_tx.sv
// Bench for led_value_uart_tx at 10 clocks per bit. Directed scenarios
// compare tx, busy and overrun cycle by cycle against hand-derived frames.
// A line receiver decodes the bytes that appear on tx.
module tb_led_value_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] value;
  logic       tx;
  logic       busy;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  int         frame_err = 0;

  led_value_uart_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .value  (value),
    .tx     (tx),
    .busy   (busy),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level at position pos (0..99) of a frame carrying b
  function automatic logic exp_frame_bit(logic [7:0] b, int pos);
    logic [7:0] bb;
    bb = b;
    if (pos < 10) return 1'b0;
    if (pos < 90) return bb[(pos - 10) / 10];
    return 1'b1;
  endfunction

  // Line receiver: finds the falling start edge and samples each bit at mid-bit
  initial begin : rx_monitor
    logic       active;
    int         cnt;
    logic [7:0] sh;
    active = 1'b0;
    cnt    = 0;
    sh     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1;
          cnt    = 0;
        end
      end else begin
        cnt++;
        if (cnt >= 15 && cnt <= 85 && (cnt % 10) == 5) sh[(cnt - 15) / 10] = tx;
        if (cnt == 95) begin
          if (tx !== 1'b1) frame_err++;
          rx_q.push_back(sh);
          active = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    value = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL reset_idle_stable bad_cycles=%0d exp=0", bad); end
    checks++;
    if (rx_q.size() != 0) begin failures++; $display("FAIL reset_no_frame frames=%0d exp=0", rx_q.size()); end
  endtask

  // 0x00 -> 0xA5 from idle: one frame, busy exactly 100 cycles
  task automatic test_single_frame();
    int tx_bad, ov_bad, busy_cnt, n0;
    tx_bad = 0; ov_bad = 0; busy_cnt = 0;
    n0 = rx_q.size();
    @(negedge clk);
    value = 8'hA5;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (tx !== ((i < 100) ? exp_frame_bit(8'hA5, i) : 1'b1)) tx_bad++;
      if (busy === 1'b1) busy_cnt++;
      if (busy !== (i < 100)) ov_bad++;
      if (overrun !== 1'b0) ov_bad++;
    end
    checks++;
    if (tx_bad != 0) begin failures++; $display("FAIL a5_tx_waveform bad_cycles=%0d exp=0", tx_bad); end
    checks++;
    if (busy_cnt != 100) begin failures++; $display("FAIL a5_busy_len got=%0d exp=100", busy_cnt); end
    checks++;
    if (ov_bad != 0) begin failures++; $display("FAIL a5_busy_overrun_shape bad_cycles=%0d exp=0", ov_bad); end
    checks++;
    if (rx_q.size() != n0 + 1 || rx_q[rx_q.size() - 1] !== 8'hA5)
      begin failures++; $display("FAIL a5_rx_byte frames=%0d exp=%0d", rx_q.size() - n0, 1); end
  endtask

  // 0x01, then 0x02 at cycle 30: pending byte goes out with no idle gap
  task automatic test_pending();
    int tx_bad, busy_bad, ov_cnt, n0;
    logic [7:0] fr [0:1];
    fr[0] = 8'h01; fr[1] = 8'h02;
    tx_bad = 0; busy_bad = 0; ov_cnt = 0;
    n0 = rx_q.size();
    @(negedge clk);
    value = 8'h01;
    for (int i = 0; i < 215; i++) begin
      @(negedge clk);
      if (tx !== ((i < 200) ? exp_frame_bit(fr[i / 100], i % 100) : 1'b1)) tx_bad++;
      if (busy !== (i < 200)) busy_bad++;
      if (overrun === 1'b1) ov_cnt++;
      if (i == 29) value = 8'h02;
    end
    checks++;
    if (tx_bad != 0) begin failures++; $display("FAIL pend_tx_waveform bad_cycles=%0d exp=0", tx_bad); end
    checks++;
    if (busy_bad != 0) begin failures++; $display("FAIL pend_busy bad_cycles=%0d exp=0", busy_bad); end
    checks++;
    if (ov_cnt != 0) begin failures++; $display("FAIL pend_overrun got=%0d exp=0", ov_cnt); end
    checks++;
    if (rx_q.size() != n0 + 2) begin failures++; $display("FAIL pend_frames got=%0d exp=2", rx_q.size() - n0); end
  endtask

  // 0x01, 0x02 at 20, 0x03 at 40: 0x02 is dropped with one overrun pulse
  task automatic test_overrun();
    int tx_bad, busy_bad, ov_bad, ov_cnt;
    logic [7:0] fr [0:1];
    fr[0] = 8'h01; fr[1] = 8'h03;
    tx_bad = 0; busy_bad = 0; ov_bad = 0; ov_cnt = 0;
    @(negedge clk);
    value = 8'h01;
    for (int i = 0; i < 215; i++) begin
      @(negedge clk);
      if (tx !== ((i < 200) ? exp_frame_bit(fr[i / 100], i % 100) : 1'b1)) tx_bad++;
      if (busy !== (i < 200)) busy_bad++;
      if (overrun !== (i == 40)) ov_bad++;
      if (overrun === 1'b1) ov_cnt++;
      if (i == 19) value = 8'h02;
      if (i == 39) value = 8'h03;
    end
    checks++;
    if (tx_bad != 0) begin failures++; $display("FAIL ovr_tx_waveform bad_cycles=%0d exp=0", tx_bad); end
    checks++;
    if (busy_bad != 0) begin failures++; $display("FAIL ovr_busy bad_cycles=%0d exp=0", busy_bad); end
    checks++;
    if (ov_cnt != 1) begin failures++; $display("FAIL ovr_pulse_count got=%0d exp=1", ov_cnt); end
    checks++;
    if (ov_bad != 0) begin failures++; $display("FAIL ovr_pulse_timing bad_cycles=%0d exp=0", ov_bad); end
    checks++;
    if (rx_q[rx_q.size() - 1] !== 8'h03 || rx_q[rx_q.size() - 2] !== 8'h01)
      begin failures++; $display("FAIL ovr_rx_bytes got=%h,%h exp=01,03", rx_q[rx_q.size() - 2], rx_q[rx_q.size() - 1]); end
  endtask

  // Reset mid-frame (0x00 frame, cycle 45): line idles at once, no frame afterwards
  task automatic test_reset_abort();
    int tx_bad, idle_bad, n0;
    tx_bad = 0; idle_bad = 0;
    n0 = rx_q.size();
    @(negedge clk);
    value = 8'h00;
    for (int i = 0; i <= 45; i++) begin
      @(negedge clk);
      if (tx !== exp_frame_bit(8'h00, i)) tx_bad++;
    end
    checks++;
    if (tx_bad != 0) begin failures++; $display("FAIL abort_pre_tx bad_cycles=%0d exp=0", tx_bad); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL abort_async_tx got=%b exp=1", tx); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_async_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) idle_bad++;
    end
    checks++;
    if (idle_bad != 0) begin failures++; $display("FAIL abort_post_idle bad_cycles=%0d exp=0", idle_bad); end
    checks++;
    if (rx_q.size() != n0) begin failures++; $display("FAIL abort_no_frame frames=%0d exp=0", rx_q.size() - n0); end
  endtask

  // 0x55 held through reset release: a single frame starting on the first edge
  task automatic test_reset_nonzero();
    int tx_bad, busy_cnt, n0;
    tx_bad = 0; busy_cnt = 0;
    @(negedge clk);
    rst_n = 1'b0;
    value = 8'h55;
    repeat (3) @(negedge clk);
    n0 = rx_q.size();
    rst_n = 1'b1;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (tx !== ((i < 100) ? exp_frame_bit(8'h55, i) : 1'b1)) tx_bad++;
      if (busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (tx_bad != 0) begin failures++; $display("FAIL rel55_tx_waveform bad_cycles=%0d exp=0", tx_bad); end
    checks++;
    if (busy_cnt != 100) begin failures++; $display("FAIL rel55_busy_len got=%0d exp=100", busy_cnt); end
    checks++;
    if (rx_q.size() != n0 + 1 || rx_q[rx_q.size() - 1] !== 8'h55)
      begin failures++; $display("FAIL rel55_rx frames=%0d exp=1", rx_q.size() - n0); end
  endtask

  // Value +1 every 50 cycles: frames 56,57,59,5B..69 back to back, overruns at 150..950
  task automatic test_back_to_back();
    int tx_bad, busy_bad, ov_bad, ov_cnt, n0, rx_bad;
    logic [7:0] fr [0:10];
    fr[0] = 8'h56;
    fr[1] = 8'h57;
    for (int k = 2; k <= 10; k++) fr[k] = 8'(8'h56 + 2 * k - 1);
    tx_bad = 0; busy_bad = 0; ov_bad = 0; ov_cnt = 0; rx_bad = 0;
    n0 = rx_q.size();
    @(negedge clk);
    value = 8'h56;
    for (int i = 0; i < 1150; i++) begin
      @(negedge clk);
      if (tx !== ((i < 1100) ? exp_frame_bit(fr[i / 100], i % 100) : 1'b1)) tx_bad++;
      if (busy !== (i < 1100)) busy_bad++;
      if (overrun !== (i >= 150 && i <= 950 && (i % 100) == 50)) ov_bad++;
      if (overrun === 1'b1) ov_cnt++;
      if ((i % 50) == 49 && i < 950) value = value + 8'h01;
    end
    checks++;
    if (tx_bad != 0) begin failures++; $display("FAIL b2b_tx_waveform bad_cycles=%0d exp=0", tx_bad); end
    checks++;
    if (busy_bad != 0) begin failures++; $display("FAIL b2b_busy_continuous bad_cycles=%0d exp=0", busy_bad); end
    checks++;
    if (ov_cnt != 9) begin failures++; $display("FAIL b2b_overrun_count got=%0d exp=9", ov_cnt); end
    checks++;
    if (ov_bad != 0) begin failures++; $display("FAIL b2b_overrun_timing bad_cycles=%0d exp=0", ov_bad); end
    if (rx_q.size() != n0 + 11) rx_bad = 100;
    else for (int k = 0; k <= 10; k++) if (rx_q[n0 + k] !== fr[k]) rx_bad++;
    checks++;
    if (rx_bad != 0) begin failures++; $display("FAIL b2b_rx_bytes bad=%0d frames=%0d exp=11", rx_bad, rx_q.size() - n0); end
  endtask

  initial begin
    rst_n = 1'b0;
    value = 8'h00;
    test_reset();
    test_single_frame();
    test_pending();
    test_overrun();
    test_reset_abort();
    test_reset_nonzero();
    test_back_to_back();
    checks++;
    if (frame_err != 0) begin failures++; $display("FAIL stop_bits errors=%0d exp=0", frame_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    failures++;
    $display("FAIL watchdog timeout reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
